// File: rtl/mips_regfile_pkg.sv
// rtl/mips_regfile_pkg.sv - shared constants and index type for the MIPS register bank
package mips_regfile_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_GP   = 5'd28;
    localparam reg_idx_t REG_SP   = 5'd29;

    localparam logic [31:0] DEFAULT_SP_RESET = 32'h7FFF_EFFC;
    localparam logic [31:0] DEFAULT_GP_RESET = 32'h1000_8000;

endpackage

// File: rtl/decoder_5to32.sv
// rtl/decoder_5to32.sv - one-hot register index decoder, r0 never selected
module decoder_5to32
    import mips_regfile_pkg::*;
(
    input  reg_idx_t              idx,
    input  logic                  en,
    output logic [NUM_REGS-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en && (idx != REG_ZERO)) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/register_bank_scoreboard.sv
// rtl/register_bank_scoreboard.sv - 32-entry register storage with per-register busy scoreboard
module register_bank_scoreboard
    import mips_regfile_pkg::*;
#(
    parameter int          N        = 32,
    parameter logic [31:0] SP_RESET = DEFAULT_SP_RESET,
    parameter logic [31:0] GP_RESET = DEFAULT_GP_RESET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_RegWrite_1,
    input  logic [4:0]            in_WriteRegister_5,
    input  logic [N-1:0]          in_WriteData_dw,
    input  logic                  in_Issue_1,
    input  logic [4:0]            in_IssueRegister_5,
    output logic [NUM_REGS*N-1:0] o_Regs_flat,
    output logic [NUM_REGS-1:0]   o_Busy_32
);

    logic [NUM_REGS-1:0] write_vec;
    logic [NUM_REGS-1:0] issue_vec;
    logic [NUM_REGS-1:0] busy_q;

    decoder_5to32 u_write_dec (
        .idx    (in_WriteRegister_5),
        .en     (in_RegWrite_1),
        .onehot (write_vec)
    );

    decoder_5to32 u_issue_dec (
        .idx    (in_IssueRegister_5),
        .en     (in_Issue_1),
        .onehot (issue_vec)
    );

    assign o_Regs_flat[N-1:0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        localparam logic [N-1:0] RST_VAL =
            (i == int'(REG_SP)) ? N'(SP_RESET) :
            (i == int'(REG_GP)) ? N'(GP_RESET) : '0;

        logic [N-1:0] q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q <= RST_VAL;
            end else if (write_vec[i]) begin
                q <= in_WriteData_dw;
            end
        end

        assign o_Regs_flat[i*N +: N] = q;
    end

    // Set after clear: a same-cycle issue to the written register keeps it busy for the new producer.
    // Bit 0 stays low because neither decoder ever selects r0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~write_vec) | issue_vec;
        end
    end

    assign o_Busy_32 = busy_q;

endmodule

// File: tb/tb_register_bank_scoreboard.sv
// tb/tb_register_bank_scoreboard.sv - directed self-checking bench for register_bank_scoreboard
module tb_register_bank_scoreboard;

    localparam int N = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            reg_write;
    logic [4:0]      write_reg;
    logic [N-1:0]    write_data;
    logic            issue;
    logic [4:0]      issue_reg;
    logic [32*N-1:0] regs_flat;
    logic [31:0]     busy;

    int n_cmp = 0;
    int n_err = 0;

    register_bank_scoreboard #(.N(N)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_RegWrite_1      (reg_write),
        .in_WriteRegister_5 (write_reg),
        .in_WriteData_dw    (write_data),
        .in_Issue_1         (issue),
        .in_IssueRegister_5 (issue_reg),
        .o_Regs_flat        (regs_flat),
        .o_Busy_32          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] rv(input int i);
        return regs_flat[i*N +: N];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wi, input logic [N-1:0] wd,
                         input logic is, input logic [4:0] ii);
        reg_write  = we;
        write_reg  = wi;
        write_data = wd;
        issue      = is;
        issue_reg  = ii;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        repeat (2) @(negedge clk);

        check("rst_r29", rv(29), 32'h7FFF_EFFC);
        check("rst_r28", rv(28), 32'h1000_8000);
        check("rst_r0", rv(0), 32'h0);
        check("rst_r5", rv(5), 32'h0);
        check("rst_r31", rv(31), 32'h0);
        check("rst_busy", busy, 32'h0);
        reset = 1'b0;

        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
        #1 check("r5_same_cycle", rv(5), 32'h0);
        @(negedge clk);
        check("r5_after_edge", rv(5), 32'hDEAD_BEEF);
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        @(negedge clk);
        check("r0_write_ignored", rv(0), 32'h0);
        check("busy_after_writes", busy, 32'h0);

        drive(1'b0, 5'd0, '0, 1'b1, 5'd8);
        @(negedge clk);
        check("issue_r8_busy", busy, 32'h0000_0100);
        drive(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0);
        @(negedge clk);
        check("wb_r8_busy", busy, 32'h0);
        check("wb_r8_data", rv(8), 32'h1234);

        drive(1'b1, 5'd9, 32'h55, 1'b1, 5'd9);
        @(negedge clk);
        check("same_idx_data", rv(9), 32'h55);
        check("same_idx_busy", busy, 32'h0000_0200);
        drive(1'b1, 5'd11, 32'hAA, 1'b1, 5'd10);
        @(negedge clk);
        check("diff_idx_busy", busy, 32'h0000_0600);
        check("diff_idx_r11", rv(11), 32'hAA);

        drive(1'b0, 5'd0, '0, 1'b1, 5'd0);
        @(negedge clk);
        check("issue_r0_busy", busy, 32'h0000_0600);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd12);
        @(negedge clk);
        @(negedge clk);
        check("issue_r12_twice", busy, 32'h0000_1600);
        drive(1'b1, 5'd12, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        check("wb_r12_clears", busy, 32'h0000_0600);

        drive(1'b1, 5'd4, 32'h7, 1'b1, 5'd3);
        @(negedge clk);
        check("pre_rst_busy", busy, 32'h0000_0608);
        check("pre_rst_r4", rv(4), 32'h7);
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_r4", rv(4), 32'h0);
        check("async_rst_busy", busy, 32'h0);
        check("async_rst_r29", rv(29), 32'h7FFF_EFFC);
        check("async_rst_r5", rv(5), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_r28", rv(28), 32'h1000_8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
